// File: rtl/wbuf_id_allocator_pkg.sv
// Shared configuration types for the write-buffer ID allocator and its crossbar neighbours.
package wbuf_id_allocator_pkg;

    typedef struct packed {
        logic [31:0] wbufSize;
    } mpc_u_cfg_t;

    typedef struct packed {
        mpc_u_cfg_t  u;
        logic [31:0] wbufWidth;
    } mpc_cfg_t;

    localparam mpc_cfg_t DEFAULT_CFG = '{u: '{wbufSize: 32'd4}, wbufWidth: 32'd2};

    // The free count needs one extra bit so that "all N free" is representable.
    localparam int FREE_CNT_W = int'(DEFAULT_CFG.wbufWidth) + 1;

    function automatic int free_cnt_w(mpc_cfg_t cfg);
        return int'(cfg.wbufWidth) + 1;
    endfunction

    typedef struct packed {
        logic                                  valid;
        logic [int'(DEFAULT_CFG.wbufWidth)-1:0] id;
    } wbuf_alloc_t;

endpackage

// File: rtl/wbuf_id_allocator_if.sv
// Allocation / free / status bundle between the store requester and the ID allocator.
interface wbuf_id_allocator_if
    import wbuf_id_allocator_pkg::*;
#(
    parameter mpc_cfg_t Cfg = DEFAULT_CFG
);
    localparam int W  = int'(Cfg.wbufWidth);
    localparam int CW = free_cnt_w(Cfg);

    typedef logic [W-1:0] wbufWidth_t;

    logic          alloc_valid;
    logic          alloc_ready;
    wbufWidth_t    alloc_id;
    logic          free_valid;
    wbufWidth_t    free_id;
    logic [CW-1:0] free_cnt;
    logic          all_free;
    logic          alloc_low;
    logic          err_double_free;
    wbufWidth_t    err_id;

    modport master (
        output alloc_valid, free_valid, free_id,
        input  alloc_ready, alloc_id, free_cnt, all_free, alloc_low, err_double_free, err_id
    );

    modport slave (
        input  alloc_valid, free_valid, free_id,
        output alloc_ready, alloc_id, free_cnt, all_free, alloc_low, err_double_free, err_id
    );

endinterface

// File: rtl/wbuf_id_allocator_prio_enc.sv
// Lowest-set-bit encoder: one-hot and binary index of the least significant request, plus any.
module ns_prio_enc_lsb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] one_hot,
    output logic [W-1:0] bin,
    output logic         any
);

    // Two's-complement trick isolates the lowest set bit.
    assign one_hot = req & (~req + N'(1));
    assign any     = |req;

    always_comb begin
        bin = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) bin = W'(i);
        end
    end

endmodule

// File: rtl/wbuf_id_allocator.sv
// Free-list manager for write-buffer entry IDs: lowest-free allocation, reclaim, occupancy, double-free trap.
module wbuf_id_allocator
    import wbuf_id_allocator_pkg::*;
#(
    parameter mpc_cfg_t Cfg       = DEFAULT_CFG,
    parameter int       LOW_WATER = 2
) (
    input  logic                clk,
    input  logic                rst,
    wbuf_id_allocator_if.slave  bus
);

    localparam int N  = int'(Cfg.u.wbufSize);
    localparam int W  = int'(Cfg.wbufWidth);
    localparam int CW = free_cnt_w(Cfg);

    logic [N-1:0]  free_map;
    logic [N-1:0]  free_map_nxt;
    logic [CW-1:0] free_cnt;
    logic [CW-1:0] free_cnt_nxt;
    logic          err_double_free;
    logic [W-1:0]  err_id;

    logic [N-1:0]  grant_oh;
    logic [W-1:0]  grant_id;
    logic          any_free;
    logic [N-1:0]  free_oh;
    logic          alloc_fire;
    logic          free_legal;
    logic          double_free;

    ns_prio_enc_lsb #(.N(N), .W(W)) u_prio_enc (
        .req     (free_map),
        .one_hot (grant_oh),
        .bin     (grant_id),
        .any     (any_free)
    );

    // An out-of-range free_id decodes to no bit, so it falls into the double-free path.
    always_comb begin
        free_oh = '0;
        for (int i = 0; i < N; i++) begin
            free_oh[i] = bus.free_valid && (bus.free_id == W'(i));
        end
    end

    assign alloc_fire  = bus.alloc_valid && any_free;
    assign free_legal  = |(free_oh & ~free_map);
    assign double_free = bus.free_valid && !free_legal;

    always_comb begin
        free_map_nxt = free_map;
        if (alloc_fire) free_map_nxt = free_map_nxt & ~grant_oh;
        if (free_legal) free_map_nxt = free_map_nxt | free_oh;
        free_cnt_nxt = free_cnt;
        if (alloc_fire && !free_legal)      free_cnt_nxt = free_cnt - CW'(1);
        else if (!alloc_fire && free_legal) free_cnt_nxt = free_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_map        <= '1;
            free_cnt        <= CW'(N);
            err_double_free <= 1'b0;
            err_id          <= '0;
        end else begin
            free_map <= free_map_nxt;
            free_cnt <= free_cnt_nxt;
            if (double_free && !err_double_free) begin
                err_double_free <= 1'b1;
                err_id          <= bus.free_id;
            end
        end
    end

    assign bus.alloc_ready     = any_free;
    assign bus.alloc_id        = grant_id;
    assign bus.free_cnt        = free_cnt;
    assign bus.all_free        = (free_cnt == CW'(N));
    assign bus.alloc_low       = (free_cnt <= CW'(LOW_WATER));
    assign bus.err_double_free = err_double_free;
    assign bus.err_id          = err_id;

    a_cnt_matches_map: assert property (@(posedge clk) disable iff (rst)
        free_cnt == CW'($countones(free_map)));

endmodule
